m_cp0_unit: RTL

//  Coprocessor-0 for the P7 pipeline. Sits at M stage, directly after the M-stage

---
 rtl/m_cp0_unit.sv | 112 +++++++++++
 1 files changed

// File: rtl/m_cp0_unit.sv
// Coprocessor-0 for the P7 pipeline: SR/Cause/EPC/PRId, mtc0/mfc0 access, and the
// merged interrupt/exception request that redirects fetch to the handler.
module m_cp0_unit #(
  parameter logic [31:0] PRID_VAL   = 32'h0000_7007,
  parameter logic [31:0] HANDLER_PC = 32'h0000_4180
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  input  logic [4:0]  CP0Add,
  input  logic [31:0] CP0In,
  output logic [31:0] CP0Out,
  input  logic [31:0] VPC,
  input  logic        BDIn,
  input  logic [4:0]  ExcCodeIn,
  input  logic [5:0]  HWInt,
  input  logic        EXLClr,
  output logic [31:0] EPCOut,
  output logic [31:0] HandlerPC,
  output logic        Req
);

  localparam logic [4:0] ADDR_SR    = 5'd12;
  localparam logic [4:0] ADDR_CAUSE = 5'd13;
  localparam logic [4:0] ADDR_EPC   = 5'd14;
  localparam logic [4:0] ADDR_PRID  = 5'd15;

  logic [5:0]  im_q, im_d;
  logic        exl_q, exl_d;
  logic        ie_q, ie_d;
  logic        bd_q, bd_d;
  logic [5:0]  ip_q, ip_d;
  logic [4:0]  exc_code_q, exc_code_d;
  logic [31:0] epc_q, epc_d;

  logic        int_req;
  logic        exc_req;
  logic [31:0] vpc_adj;

  assign int_req   = (|(HWInt & im_q)) & ie_q & ~exl_q;
  assign exc_req   = (ExcCodeIn != 5'd0) & ~exl_q;
  assign Req       = int_req | exc_req;
  assign vpc_adj   = BDIn ? (VPC - 32'd4) : VPC;
  assign EPCOut    = epc_q;
  assign HandlerPC = HANDLER_PC;

  always_comb begin
    im_d       = im_q;
    exl_d      = exl_q;
    ie_d       = ie_q;
    bd_d       = bd_q;
    exc_code_d = exc_code_q;
    epc_d      = epc_q;
    // IP tracks the interrupt lines every cycle, whatever else happens.
    ip_d       = HWInt;
    if (Req) begin
      exl_d      = 1'b1;
      exc_code_d = int_req ? 5'd0 : ExcCodeIn;
      bd_d       = BDIn;
      epc_d      = vpc_adj & 32'hFFFF_FFFC;
    end else begin
      if (en) begin
        case (CP0Add)
          ADDR_SR: begin
            im_d  = CP0In[15:10];
            exl_d = CP0In[1];
            ie_d  = CP0In[0];
          end
          ADDR_CAUSE: exc_code_d = CP0In[6:2];
          ADDR_EPC:   epc_d      = CP0In & 32'hFFFF_FFFC;
          default:    ;
        endcase
      end
      // eret wins over the EXL bit of a simultaneous SR write.
      if (EXLClr) begin
        exl_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      im_q       <= 6'd0;
      exl_q      <= 1'b0;
      ie_q       <= 1'b0;
      bd_q       <= 1'b0;
      ip_q       <= 6'd0;
      exc_code_q <= 5'd0;
      epc_q      <= 32'd0;
    end else begin
      im_q       <= im_d;
      exl_q      <= exl_d;
      ie_q       <= ie_d;
      bd_q       <= bd_d;
      ip_q       <= ip_d;
      exc_code_q <= exc_code_d;
      epc_q      <= epc_d;
    end
  end

  always_comb begin
    CP0Out = 32'd0;
    case (CP0Add)
      ADDR_SR:    CP0Out = {16'd0, im_q, 8'd0, exl_q, ie_q};
      ADDR_CAUSE: CP0Out = {bd_q, 15'd0, ip_q, 3'd0, exc_code_q, 2'd0};
      ADDR_EPC:   CP0Out = epc_q;
      ADDR_PRID:  CP0Out = PRID_VAL;
      default:    CP0Out = 32'd0;
    endcase
  end

endmodule
